program_memory: RTL and testbench
=================================

# program_memory

BIP program memory and boot loader; the responder on the instruction-fetch interface of the control unit. After reset it collects the program as a byte stream from the UART receiver, packs byte pairs into 16-bit instruction words, and writes them sequentially from address 0. When a HLT word arrives or memory fills, it pulses `start` to release the PC. It then serves fetches, returning `Data` = mem[`Addr`] combinationally.

## Interface
Parameters:
- `len_data`, 16, instruction word width; must equal 2 × byte width.
- `len_addr`, 11, fetch address width; depth = 2**`len_addr` words.
- `len_opcode`, 5, opcode field, `Data[len_data-1:len_data-len_opcode]`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe from UART receiver.
- `Addr`  in  `len_addr`  fetch address from control unit (PC value).
- `Data`  out  `len_data`  instruction word at `Addr`.
- `start`  out  1  one-cycle pulse; program loaded, CPU may run.
- `loading`  out  1  high while the loader accepts bytes.
- `load_count`  out  `len_addr`+1  number of words written since reset.
- `load_error`  out  1  sticky; memory filled without a HLT word.

## Operation
- FSM states: WAIT_LO, WAIT_HI, START, RUN.
- Reset drives state to WAIT_LO, write pointer to 0, low-byte register to 0, `load_count` to 0, `load_error` to 0, and `start` to 0. Array contents are not cleared.
- WAIT_LO: when `rx_done`=1, latch `rx_data` as the low byte and go to WAIT_HI.
- WAIT_HI: when `rx_done`=1, write {`rx_data`, low byte} to mem[ptr], then increment ptr and `load_count`.
  - If the written word's opcode equals HLT (00000), go to START.
  - Else, if ptr was 2**`len_addr`-1, go to START and set `load_error`.
  - Otherwise return to WAIT_LO.
- START: `start`=1 for exactly this one cycle; unconditionally go to RUN.
- RUN: `rx_done` is ignored, with no writes. The block stays in RUN until `reset`. Reloading requires a reset.
- `loading` = 1 in WAIT_LO and WAIT_HI, 0 otherwise.
- `Data`:
  - 0 (HLT) while `loading`=1, so a free-running CPU cannot fetch a partial program.
  - mem[`Addr`] in START and RUN.
- Byte order is little-endian: the first byte is bits 7:0, the second is bits 15:8.
- Write pointer never wraps; the full condition is terminal.

## Timing
- Word write and state change occur on the edge where `rx_done`=1 in WAIT_HI.
- `start` is high in the cycle immediately after the HLT word's write edge.
- `Data` has zero latency from `Addr` (asynchronous array read), so the PC-to-fetch path completes in one cycle.
- `rx_done` strobes in consecutive cycles are both accepted (lo, then hi).
- `rx_done` during START is ignored.
- Reset mid-word discards the latched low byte; the next byte is treated as a low byte.
- Reset in RUN returns to WAIT_LO. The old contents stay resident but are unreachable until overwritten, because `Data`=0 while loading.

## Structure
- Shared package `bip_pkg`: opcode constants (HLT = 5'b00000 and the others), default widths, and loader state encoding.
- Sub-module `program_ram`: 2**`len_addr` × `len_data` array with one synchronous write port (we, waddr, wdata) and one asynchronous read port.
- FSM, byte packing, and counters live in `program_memory`.

## Test plan
- Load 0x01,0x08,0x00,0x00:
  - mem[0]=0x0801 and mem[1]=0x0000.
  - `load_count`=2.
  - `start` is high one cycle after the 4th strobe edge, then low.
  - `Addr`=0 gives `Data`=0x0801.
- Before the load completes, `Addr`=0 gives `Data`=0x0000 and `loading`=1. After `start`, `loading`=0.
- In RUN, send 0xFF,0xFF: mem[0] and `load_count` are unchanged, and `start` stays 0.
- Send 0x34, assert `reset` for one cycle, then send 0x00,0x00: mem[0]=0x0000 and `start` pulses. Byte 0x34 is never stored.
- Fill memory (`len_addr`=3) with 8 words 0x0801:
  - `start` pulses after the 8th word.
  - `load_error`=1 and `load_count`=8.
  - `load_error` stays 1 until `reset`.
- Back-to-back `rx_done` on consecutive cycles with 0xAA,0x09 then 0x00,0x00: mem[0]=0x09AA, followed by a correct `start` pulse.

Source files
------------

// File: rtl/bip_pkg.sv
// BIP shared definitions: default widths, opcode constants and the
// program loader state encoding used by program_memory.
package bip_pkg;

    localparam int LEN_DATA   = 16;
    localparam int LEN_ADDR   = 11;
    localparam int LEN_OPCODE = 5;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] ST_WAIT_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd1;
    localparam logic [1:0] ST_START   = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

endpackage

// File: rtl/program_ram.sv
// Instruction store: 2**len_addr x len_data words, one synchronous
// write port (we/waddr/wdata) and one asynchronous read port (raddr/rdata).
module program_ram #(
    parameter int len_data = 16,
    parameter int len_addr = 11
) (
    input  logic                clk,
    input  logic                we,
    input  logic [len_addr-1:0] waddr,
    input  logic [len_data-1:0] wdata,
    input  logic [len_addr-1:0] raddr,
    output logic [len_data-1:0] rdata
);

    logic [len_data-1:0] mem [0:(2**len_addr)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_memory.sv
// BIP program memory and UART boot loader. Packs received byte pairs
// (little-endian) into words written from address 0 until a HLT word
// arrives or memory fills, pulses start, then serves fetches.
// Ports: clk, reset (sync, active-high), rx_data/rx_done (UART bytes),
// Addr/Data (fetch), start, loading, load_count, load_error.
module program_memory
    import bip_pkg::*;
#(
    parameter int len_data   = 16,
    parameter int len_addr   = 11,
    parameter int len_opcode = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic [len_addr-1:0] Addr,
    output logic [len_data-1:0] Data,
    output logic                start,
    output logic                loading,
    output logic [len_addr:0]   load_count,
    output logic                load_error
);

    localparam logic [len_addr-1:0] PTR_MAX = '1;

    logic [1:0]          state;
    logic [len_addr-1:0] ptr;
    logic [7:0]          lo_byte;
    logic [len_data-1:0] wword;
    logic [len_data-1:0] rdata;
    logic                we;
    logic                is_hlt;

    assign wword  = {rx_data, lo_byte};
    assign is_hlt = (wword[len_data-1 -: len_opcode] == OP_HLT[len_opcode-1:0]);
    assign we     = (state == ST_WAIT_HI) && rx_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_WAIT_LO;
            ptr        <= '0;
            lo_byte    <= '0;
            load_count <= '0;
            load_error <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT_LO: begin
                    if (rx_done) begin
                        lo_byte <= rx_data;
                        state   <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_done) begin
                        load_count <= load_count + 1'b1;
                        // pointer saturates: the full condition is terminal
                        if (ptr != PTR_MAX) begin
                            ptr <= ptr + 1'b1;
                        end
                        if (is_hlt) begin
                            state <= ST_START;
                        end else if (ptr == PTR_MAX) begin
                            state      <= ST_START;
                            load_error <= 1'b1;
                        end else begin
                            state <= ST_WAIT_LO;
                        end
                    end
                end
                ST_START: state <= ST_RUN;
                ST_RUN:   state <= ST_RUN;
                default:  state <= ST_WAIT_LO;
            endcase
        end
    end

    assign start   = (state == ST_START);
    assign loading = (state == ST_WAIT_LO) || (state == ST_WAIT_HI);

    program_ram #(
        .len_data (len_data),
        .len_addr (len_addr)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr),
        .wdata (wword),
        .raddr (Addr),
        .rdata (rdata)
    );

    // a CPU fetching during load sees HLT rather than a partial program
    assign Data = loading ? '0 : rdata;

endmodule

// File: tb/tb_program_memory.sv
// Directed self-checking bench for program_memory (len_addr = 3 so the
// memory-full path can be exercised with 8 words).
module tb_program_memory;

    localparam int LD = 16;
    localparam int LA = 3;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [LA-1:0] Addr;
    logic [LD-1:0] Data;
    logic          start;
    logic          loading;
    logic [LA:0]   load_count;
    logic          load_error;

    int n_checks;
    int n_fail;

    program_memory #(
        .len_data   (LD),
        .len_addr   (LA),
        .len_opcode (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .Addr       (Addr),
        .Data       (Data),
        .start      (start),
        .loading    (loading),
        .load_count (load_count),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        Addr = '0;
        #1;
        n_checks++;
        if (loading !== 1'b1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: loading=%b start=%b, want 1 0", loading, start);
        end
        n_checks++;
        if (load_count !== 4'd0 || load_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counts: count=%0d err=%b, want 0 0", load_count, load_error);
        end
        n_checks++;
        if (Data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: Data=%h, want 0000", Data);
        end
    endtask

    task automatic test_load();
        Addr = '0;
        send_byte(8'h01);
        n_checks++;
        if (loading !== 1'b1 || Data !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_partial: loading=%b Data=%h, want 1 0000", loading, Data);
        end
        send_byte(8'h08);
        n_checks++;
        if (load_count !== 4'd1 || Data !== 16'h0000 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL load_word1: count=%0d Data=%h start=%b, want 1 0000 0",
                     load_count, Data, start);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        n_checks++;
        if (start !== 1'b1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL load_start: start=%b loading=%b, want 1 0", start, loading);
        end
        n_checks++;
        if (load_count !== 4'd2 || load_error !== 1'b0) begin
            n_fail++;
            $display("FAIL load_count: count=%0d err=%b, want 2 0", load_count, load_error);
        end
        n_checks++;
        if (Data !== 16'h0801) begin
            n_fail++;
            $display("FAIL load_mem0: Data=%h, want 0801", Data);
        end
        @(negedge clk);
        n_checks++;
        if (start !== 1'b0 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL load_start_end: start=%b loading=%b, want 0 0", start, loading);
        end
        Addr = 3'd1;
        #1;
        n_checks++;
        if (Data !== 16'h0000) begin
            n_fail++;
            $display("FAIL load_mem1: Data=%h, want 0000", Data);
        end
        Addr = '0;
    endtask

    task automatic test_run_ignore();
        int starts;
        starts = 0;
        Addr = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rx_data = 8'hFF;
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            if (start !== 1'b0) starts++;
        end
        @(negedge clk);
        if (start !== 1'b0) starts++;
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL run_start: start seen %0d times, want 0", starts);
        end
        n_checks++;
        if (Data !== 16'h0801 || load_count !== 4'd2) begin
            n_fail++;
            $display("FAIL run_ignore: Data=%h count=%0d, want 0801 2", Data, load_count);
        end
    endtask

    task automatic test_reset_midword();
        do_reset();
        send_byte(8'h34);
        do_reset();
        Addr = '0;
        send_byte(8'h00);
        n_checks++;
        if (load_count !== 4'd0 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lo: count=%0d start=%b, want 0 0", load_count, start);
        end
        send_byte(8'h00);
        n_checks++;
        if (start !== 1'b1 || Data !== 16'h0000 || load_count !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_word: start=%b Data=%h count=%0d, want 1 0000 1",
                     start, Data, load_count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_byte(8'h01);
            send_byte(8'h08);
        end
        n_checks++;
        if (start !== 1'b0 || loading !== 1'b1 || load_count !== 4'd7) begin
            n_fail++;
            $display("FAIL fill_7: start=%b loading=%b count=%0d, want 0 1 7",
                     start, loading, load_count);
        end
        send_byte(8'h01);
        send_byte(8'h08);
        n_checks++;
        if (start !== 1'b1 || load_error !== 1'b1 || load_count !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_8: start=%b err=%b count=%0d, want 1 1 8",
                     start, load_error, load_count);
        end
        @(negedge clk);
        Addr = 3'd7;
        #1;
        n_checks++;
        if (start !== 1'b0 || load_error !== 1'b1 || Data !== 16'h0801) begin
            n_fail++;
            $display("FAIL fill_after: start=%b err=%b Data=%h, want 0 1 0801",
                     start, load_error, Data);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        Addr = 3'd0;
        #1;
        n_checks++;
        if (load_error !== 1'b1 || load_count !== 4'd8 || Data !== 16'h0801) begin
            n_fail++;
            $display("FAIL fill_sticky: err=%b count=%0d Data=%h, want 1 8 0801",
                     load_error, load_count, Data);
        end
        do_reset();
        n_checks++;
        if (load_error !== 1'b0 || load_count !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_reset: err=%b count=%0d, want 0 0", load_error, load_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq[0] = 8'hAA;
        seq[1] = 8'h09;
        seq[2] = 8'h00;
        seq[3] = 8'h00;
        do_reset();
        Addr = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = seq[i];
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        n_checks++;
        if (start !== 1'b1 || load_count !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_start: start=%b count=%0d, want 1 2", start, load_count);
        end
        n_checks++;
        if (Data !== 16'h09AA) begin
            n_fail++;
            $display("FAIL b2b_mem0: Data=%h, want 09aa", Data);
        end
        @(negedge clk);
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse: start=%b, want 0", start);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rx_data  = '0;
        rx_done  = 1'b0;
        Addr     = '0;
        test_reset();
        test_load();
        test_run_ignore();
        test_reset_midword();
        test_fill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
